// File: rtl/stream_buffer_mem.sv
// stream_buffer_mem: DEPTH x WIDTH buffer with in-order pop, offset peek,
// occupancy count and sticky overflow/underflow errors.
module stream_buffer_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int IN_W  = 20,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_valid,
    input  logic [IN_W-1:0]  wr_data,
    output logic             wr_ready,
    input  logic             rd_pop,
    input  logic             rd_peek,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    if (IN_W > WIDTH) begin : g_bad_in_w
        $error("stream_buffer_mem: IN_W must not exceed WIDTH");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("stream_buffer_mem: DEPTH must be at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, peek_ptr;
    logic [AW:0]      peek_sum;
    logic             do_wr, do_pop, do_peek;

    assign full     = count == DEPTH_C;
    assign empty    = count == '0;
    assign wr_ready = !full;
    assign do_wr    = wr_valid && !full && !clear;
    assign do_pop   = rd_pop && !empty;
    assign do_peek  = rd_peek && !rd_pop && ({1'b0, rd_addr} < count);
    // Offset addition wraps modulo DEPTH, which need not be a power of two.
    assign peek_sum = {1'b0, rd_ptr} + {1'b0, rd_addr};
    assign peek_ptr = peek_sum >= DEPTH_C ? AW'(peek_sum - DEPTH_C) : peek_sum[AW-1:0];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= WIDTH'(wr_data);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
            if (do_pop || do_peek) rd_data <= mem[do_pop ? rd_ptr : peek_ptr];
            count     <= count + (AW+1)'(do_wr) - (AW+1)'(do_pop);
            rd_valid  <= do_pop || do_peek;
            overflow  <= overflow || (wr_valid && full);
            underflow <= underflow || (rd_pop && empty);
        end
    end
endmodule

// File: tb/tb_stream_buffer_mem.sv
// tb_stream_buffer_mem: directed checks of fill/drain, wrap, simultaneous
// write+pop, peek and reset/clear behaviour.
module tb_stream_buffer_mem;
    logic        clk = 0, rst = 0, clear = 0, wr_valid = 0, rd_pop = 0, rd_peek = 0;
    logic [19:0] wr_data = '0;
    logic [7:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic [8:0]  count;
    logic        wr_ready, rd_valid, full, empty, overflow, underflow;
    logic [31:0] q [$];
    logic [31:0] e;
    int          tests = 0, fails = 0;

    stream_buffer_mem dut (
        .clk(clk), .rst(rst), .clear(clear), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .rd_pop(rd_pop), .rd_peek(rd_peek), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .full(full),
        .empty(empty), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [19:0] d);
        wr_valid = 1;
        wr_data  = d;
        cyc();
        wr_valid = 0;
        if (q.size() < 256) q.push_back({12'h0, d});
    endtask

    task automatic pop_chk(input string tag);
        rd_pop = 1;
        cyc();
        rd_pop = 0;
        e = q.pop_front();
        chk(tag, {rd_valid, rd_data}, {1'b1, e});
    endtask

    task automatic do_clear();
        clear = 1;
        cyc();
        clear = 0;
    endtask

    initial begin
        // 1: async reset values, fill, overflow
        #2 rst = 1;
        #1;
        chk("reset", {count, empty, full, wr_ready, rd_data, rd_valid, overflow, underflow},
            {9'd0, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0});
        rst = 0;
        for (int i = 0; i < 256; i++) wr(20'(i));
        chk("fill", {count, full, wr_ready, overflow}, {9'd256, 1'b1, 1'b0, 1'b0});
        wr(20'h12345);
        chk("overflow", {count, overflow}, {9'd256, 1'b1});
        // 2: drain in order, underflow
        for (int i = 0; i < 256; i++) pop_chk("drain");
        chk("drained", {count, empty}, {9'd0, 1'b1});
        rd_pop = 1;
        cyc();
        rd_pop = 0;
        chk("underflow", {underflow, rd_valid, count}, {1'b1, 1'b0, 9'd0});
        do_clear();
        chk("clear_flags", {overflow, underflow, count, empty}, {1'b0, 1'b0, 9'd0, 1'b1});
        // 3: pointer wrap
        for (int i = 0; i < 200; i++) wr(20'h01000 + 20'(i));
        for (int i = 0; i < 150; i++) pop_chk("wrap_pop1");
        for (int i = 0; i < 200; i++) wr(20'h02000 + 20'(i));
        chk("wrap_count", count, 250);
        for (int i = 0; i < 250; i++) pop_chk("wrap_pop2");
        chk("wrap_empty", {count, empty}, {9'd0, 1'b1});
        // 4: simultaneous write+pop, mid-range and at full
        for (int i = 0; i < 5; i++) wr(20'h00400 + 20'(i));
        wr_valid = 1; wr_data = 20'h004AA; rd_pop = 1;
        cyc();
        wr_valid = 0; rd_pop = 0;
        e = q.pop_front();
        q.push_back(32'h004AA);
        chk("wp_mid", {count, rd_valid, rd_data}, {9'd5, 1'b1, e});
        for (int i = 0; i < 251; i++) wr(20'h00500 + 20'(i));
        chk("wp_full", {count, full}, {9'd256, 1'b1});
        wr_valid = 1; wr_data = 20'h00777; rd_pop = 1;
        cyc();
        wr_valid = 0; rd_pop = 0;
        e = q.pop_front();
        chk("wp_full_res", {count, overflow, rd_valid, rd_data}, {9'd255, 1'b1, 1'b1, e});
        for (int i = 0; i < 255; i++) pop_chk("wp_drain");
        do_clear();
        // 5: peek
        for (int i = 0; i < 10; i++) wr(20'h00300 + 20'(i));
        rd_peek = 1; rd_addr = 3;
        cyc();
        chk("peek3", {rd_valid, rd_data, count}, {1'b1, 32'h00000303, 9'd10});
        rd_addr = 10;
        cyc();
        chk("peek_oob", {rd_valid, rd_data}, {1'b0, 32'h00000303});
        rd_pop = 1; rd_addr = 3;
        cyc();
        rd_pop = 0; rd_peek = 0;
        chk("pop_prio", {rd_valid, rd_data, count}, {1'b1, 32'h00000300, 9'd9});
        wr(20'hFFFFF);
        rd_peek = 1; rd_addr = 9;
        cyc();
        rd_peek = 0;
        chk("peek_zext", {rd_valid, rd_data}, {1'b1, 32'h000FFFFF});
        cyc();
        chk("idle_hold", {rd_valid, rd_data}, {1'b0, 32'h000FFFFF});
        // 6: async reset mid-burst, clear with write, underflow with write
        wr_valid = 1; wr_data = 20'h00AAA;
        cyc();
        cyc();
        #2 rst = 1;
        #1;
        chk("rst_mid", {count, empty, full, wr_ready, rd_data, rd_valid, overflow, underflow},
            {9'd0, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0});
        rst = 0; wr_valid = 0;
        q.delete();
        for (int i = 0; i < 257; i++) wr(20'(i));
        chk("ovf_again", {count, overflow}, {9'd256, 1'b1});
        clear = 1; wr_valid = 1; wr_data = 20'h00BBB;
        cyc();
        clear = 0; wr_valid = 0;
        chk("clear_wr", {count, empty, overflow}, {9'd0, 1'b1, 1'b0});
        wr_valid = 1; wr_data = 20'h00CCC; rd_pop = 1;
        cyc();
        wr_valid = 0; rd_pop = 0;
        chk("uf_wr", {underflow, count, rd_valid}, {1'b1, 9'd1, 1'b0});
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
